// File: rtl/ram_stream_ctrl.sv
// Arbitrates a single-port 1024x32 RAM between a host write port (idle) and a
// read sequencer that streams a word range out as one Avalon-ST packet.
module ram_stream_ctrl #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [WIDTH-1:0]  ram_data,
  input  logic [WIDTH-1:0]  ram_q,
  input  logic              ready,
  output logic [WIDTH-1:0]  data,
  output logic              valid,
  output logic              sop,
  output logic              eop,
  output logic              empty
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic              busy_q, done_q;

  logic              infl_q, infl_sop_q, infl_eop_q;
  logic [WIDTH-1:0]  fdata_q [2];
  logic              fsop_q  [2];
  logic              feop_q  [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q, count_d;

  logic              pop, issue, issue_sop, issue_eop;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] run_addr;

  // Credit counts the in-flight read so the 2-entry FIFO can never overflow.
  always_comb begin
    pop       = valid & ready;
    occupancy = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
    issue     = (state_q == RUN) && (issued_q < len_q) && (occupancy < 3'd2);
    issue_sop = (issued_q == '0);
    issue_eop = (issued_q == len_q - LEN_W'(1));
    run_addr  = base_q + issued_q[ADDR_W-1:0];
    issued_d  = issue ? issued_q + LEN_W'(1) : issued_q;
    count_d   = count_q + {1'b0, infl_q} - {1'b0, pop};
  end

  assign wr_ready = (state_q == IDLE) & ~rst;
  assign ram_wren = wr_ready & wr_en;
  assign ram_addr = (state_q == IDLE) ? wr_addr : run_addr;
  assign ram_data = wr_data;
  assign valid    = (count_q != 2'd0);
  assign data     = fdata_q[rd_ptr_q];
  assign sop      = valid & fsop_q[rd_ptr_q];
  assign eop      = valid & feop_q[rd_ptr_q];
  assign busy     = busy_q;
  assign done     = done_q;
  assign empty    = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (length != '0)) begin
            base_q   <= start_addr;
            len_q    <= length;
            issued_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          issued_q <= issued_d;
          if (pop && eop) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q     <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fdata_q[i] <= '0;
        fsop_q[i]  <= 1'b0;
        feop_q[i]  <= 1'b0;
      end
    end else begin
      infl_q     <= issue;
      infl_sop_q <= issue_sop;
      infl_eop_q <= issue_eop;
      if (infl_q) begin
        fdata_q[wr_ptr_q] <= ram_q;
        fsop_q[wr_ptr_q]  <= infl_sop_q;
        feop_q[wr_ptr_q]  <= infl_eop_q;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Directed bench for ram_stream_ctrl with a behavioural single-port RAM
// (registered address, unregistered q).
module tb_ram_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  start_addr;
  logic [10:0] length;
  logic        busy, done;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [9:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_data;
  logic [31:0] ram_q;
  logic        ready;
  logic [31:0] data;
  logic        valid, sop, eop, empty;

  ram_stream_ctrl #(.WIDTH(32), .ADDR_W(10), .LEN_W(11)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_data(ram_data),
    .ram_q(ram_q), .ready(ready), .data(data), .valid(valid), .sop(sop), .eop(eop),
    .empty(empty)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic [9:0]  raddr_q;
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    raddr_q <= ram_addr;
  end
  assign ram_q = mem[raddr_q];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_d [0:31];
  logic [15:0] rdy_pat = 16'b1001_0110_1100_1011;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [9:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // mode 0: ready held high with exact cycle checks; mode 1: ready from rdy_pat.
  task automatic run_pkt(input logic [9:0] a, input int len, input int mode,
                         input bit noise, input bit sw, input logic [31:0] swd);
    int cyc, nb, done_cyc, ahead, max_ahead;
    bit held;
    logic [31:0] hd;
    logic hs, he;
    start = 1'b1; start_addr = a; length = 11'(len);
    if (sw) begin wr_en = 1'b1; wr_addr = a; wr_data = swd; end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    cyc = 1; nb = 0; done_cyc = -1; max_ahead = 0; held = 1'b0;
    hd = '0; hs = 1'b0; he = 1'b0;
    check_eq("busy_cycle1", busy, 1);
    while (cyc < 300 && done_cyc < 0) begin
      ready = (mode == 0) ? 1'b1 : rdy_pat[cyc % 16];
      if (noise && cyc == 2) begin
        wr_en = 1'b1; wr_addr = 10'd3; wr_data = 32'h0000_0BAD;
        start = 1'b1; start_addr = 10'd200; length = 11'd5;
      end
      if (noise && cyc == 3) begin
        check_eq("run_wr_ready", wr_ready, 0);
        check_eq("run_ram_wren", ram_wren, 0);
      end
      if (held) check_eq("stall_hold", {valid, sop, eop, data}, {1'b1, hs, he, hd});
      held = 1'b0;
      if (busy && !done) begin
        ahead = ((int'(ram_addr) - int'(a)) & 1023) - nb;
        if (ahead > max_ahead) max_ahead = ahead;
      end
      if (done) begin
        done_cyc = cyc;
        start = 1'b0; wr_en = 1'b0;
      end else if (valid) begin
        if (ready) begin
          if (nb < 32) begin
            check_eq("beat_data", data, exp_d[nb]);
            check_eq("beat_sop_eop", {sop, eop}, {nb == 0, nb == len - 1});
            if (mode == 0) check_eq("beat_cycle", cyc, 3 + nb);
          end
          nb++;
        end else begin
          held = 1'b1; hd = data; hs = sop; he = eop;
        end
      end
      if (done_cyc < 0) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check_eq("done_seen", done_cyc > 0, 1);
    check_eq("beat_count", nb, len);
    if (mode == 0) check_eq("done_cycle", done_cyc, len + 3);
    if (len >= 3) check_eq("addr_ahead_max", max_ahead, 2);
    @(posedge clk); #1;
    check_eq("back_to_idle", {wr_ready, busy, done, valid}, 4'b1000);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", {valid, sop, eop, busy, done, wr_ready}, 6'b0);
    check_eq("reset_data", data, 0);
    rst = 1'b0; #1;
    check_eq("idle_wr_ready", wr_ready, 1);
    check_eq("empty_tied", empty, 0);

    for (int i = 0; i < 16; i++) write_word(10'(i), 32'(i * 3));
    check_eq("load_word7", mem[7], 21);

    for (int k = 0; k < 16; k++) exp_d[k] = 32'(k * 3);
    run_pkt(10'd0, 8, 0, 1'b0, 1'b0, '0);
    run_pkt(10'd0, 16, 1, 1'b0, 1'b0, '0);
    run_pkt(10'd0, 8, 0, 1'b1, 1'b0, '0);
    check_eq("ram_unchanged", mem[3], 9);

    write_word(10'd101, 32'h0000_0101);
    exp_d[0] = 32'h1234_5678; exp_d[1] = 32'h0000_0101;
    run_pkt(10'd100, 2, 0, 1'b0, 1'b1, 32'h1234_5678);

    for (int k = 0; k < 8; k++) exp_d[k] = 32'(k * 3);
    start = 1'b1; start_addr = 10'd0; length = 11'd8; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check_eq("pre_reset_valid", {valid, data}, {1'b1, 32'd9});
    rst = 1'b1; #1;
    check_eq("rst_wr_ready", wr_ready, 0);
    @(posedge clk); #1;
    check_eq("post_reset", {valid, sop, eop, busy, done}, 5'b0);
    check_eq("post_reset_data", data, 0);
    rst = 1'b0; #1;
    check_eq("post_reset_wr_ready", wr_ready, 1);
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || valid) saw_done = 1'b1;
    end
    check_eq("no_done_after_abort", saw_done, 0);
    run_pkt(10'd0, 8, 0, 1'b0, 1'b0, '0);

    write_word(10'd5, 32'hDEAD_BEEF);
    exp_d[0] = 32'hDEAD_BEEF;
    run_pkt(10'd5, 1, 0, 1'b0, 1'b0, '0);

    write_word(10'd1022, 32'hAAAA_1022);
    write_word(10'd1023, 32'hAAAA_1023);
    write_word(10'd0,    32'hBBBB_0000);
    write_word(10'd1,    32'hBBBB_0001);
    exp_d[0] = 32'hAAAA_1022; exp_d[1] = 32'hAAAA_1023;
    exp_d[2] = 32'hBBBB_0000; exp_d[3] = 32'hBBBB_0001;
    run_pkt(10'd1022, 4, 0, 1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
